// File: rtl/dmem_wb.sv
// MEM stage data-cache access plus MEM/WB pipeline register.
// One cache transaction per slot; load data is aligned and extended before writeback.
module dmem_wb (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_alu,
  input  logic [4:0]  in_rd,
  input  logic        in_regwrite,
  input  logic        stall_in,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_regwrite,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_reg;
  logic [31:0] rdata_reg;
  logic        wb_valid_reg;
  logic [4:0]  wb_rd_reg;
  logic        wb_regwrite_reg;
  logic [31:0] wb_data_reg;

  logic        access;
  logic        requesting;
  logic        advance;
  logic [1:0]  off;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] load_src;
  logic [7:0]  src_byte [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign access     = in_valid & (in_load | in_store);
  // HOLD already owns its response, so the request must not be re-issued there.
  assign requesting = access & (state_reg != HOLD);
  assign dmem_read  = ~rst & requesting & in_load;
  assign dmem_write = ~rst & requesting & in_store;
  assign mem_stall  = requesting & ~dmem_resp;
  assign advance    = ~mem_stall & ~stall_in;
  assign off        = in_addr[1:0];

  assign dmem_address = {in_addr[31:2], 2'b00};

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = in_rs2;
    case (in_funct3)
      3'b000: begin
        be_next    = 4'b0001 << off;
        wdata_next = in_rs2 << {off, 3'b000};
      end
      3'b001: begin
        be_next    = 4'b0011 << {in_addr[1], 1'b0};
        wdata_next = in_rs2 << {in_addr[1], 4'b0000};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = in_rs2;
      end
    endcase
  end

  assign dmem_wdata       = wdata_next;
  assign dmem_byte_enable = dmem_write ? be_next : 4'b0000;

  assign load_src = (state_reg == HOLD) ? rdata_reg : dmem_rdata;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign src_byte[gi] = load_src[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = src_byte[off];
  assign half_sel = in_addr[1] ? load_src[31:16] : load_src[15:0];

  always_comb begin
    load_data = load_src;
    case (in_funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'h000000, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'h0000, half_sel};
      default: load_data = load_src;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      rdata_reg       <= '0;
      wb_valid_reg    <= 1'b0;
      wb_rd_reg       <= '0;
      wb_regwrite_reg <= 1'b0;
      wb_data_reg     <= '0;
    end else begin
      if (dmem_resp) begin
        rdata_reg <= dmem_rdata;
      end
      case (state_reg)
        IDLE: begin
          if (access) begin
            if (dmem_resp) begin
              state_reg <= stall_in ? HOLD : IDLE;
            end else begin
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_resp) begin
            state_reg <= stall_in ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (!stall_in) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
      if (advance) begin
        wb_valid_reg    <= in_valid;
        wb_rd_reg       <= in_rd;
        wb_regwrite_reg <= in_regwrite & in_valid;
        wb_data_reg     <= in_load ? load_data : in_alu;
      end
    end
  end

  assign wb_valid    = wb_valid_reg;
  assign wb_rd       = wb_rd_reg;
  assign wb_regwrite = wb_regwrite_reg;
  assign wb_data     = wb_data_reg;

endmodule

// File: tb/tb_dmem_wb.sv
// Directed bench for dmem_wb: vector table for single-cycle accesses plus
// hand-written sequences for wait states, stall hold and reset mid-access.
module tb_dmem_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_load, in_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_rs2, in_alu;
  logic [4:0]  in_rd;
  logic        in_regwrite, stall_in;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        mem_stall, wb_valid, wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_wb dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_load          (in_load),
    .in_store         (in_store),
    .in_funct3        (in_funct3),
    .in_addr          (in_addr),
    .in_rs2           (in_rs2),
    .in_alu           (in_alu),
    .in_rd            (in_rd),
    .in_regwrite      (in_regwrite),
    .stall_in         (stall_in),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_rdata       (dmem_rdata),
    .dmem_resp        (dmem_resp),
    .mem_stall        (mem_stall),
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .wb_regwrite      (wb_regwrite),
    .wb_data          (wb_data)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        rw;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wbd;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid    = 1'b0;
    in_load     = 1'b0;
    in_store    = 1'b0;
    in_funct3   = 3'b010;
    in_addr     = '0;
    in_rs2      = '0;
    in_alu      = '0;
    in_rd       = '0;
    in_regwrite = 1'b0;
    stall_in    = 1'b0;
    dmem_resp   = 1'b0;
    dmem_rdata  = '0;
  endtask

  task automatic drive_lw(input logic [31:0] addr, input logic [4:0] rd);
    in_valid    = 1'b1;
    in_load     = 1'b1;
    in_store    = 1'b0;
    in_funct3   = 3'b010;
    in_addr     = addr;
    in_rd       = rd;
    in_regwrite = 1'b1;
  endtask

  initial begin
    int stall_cnt;
    int read_cnt;

    //        ld    st    f3      addr        rs2           alu       rdata         rd     rw    be       wdata         wb_data
    tbl[0]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h0,    32'h80FF1234, 5'd1,  1'b1, 4'b0000, 32'h0,        32'hFFFFFF80};
    tbl[1]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h0,    32'h80FF1234, 5'd2,  1'b1, 4'b0000, 32'h0,        32'h00000080};
    tbl[2]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0,        32'h0,    32'h80FF1234, 5'd3,  1'b1, 4'b0000, 32'h0,        32'h000080FF};
    tbl[3]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h0,    32'h80FF1234, 5'd4,  1'b1, 4'b0000, 32'h0,        32'hFFFF80FF};
    tbl[4]  = '{1'b1, 1'b0, 3'b001, 32'h103, 32'h0,        32'h0,    32'h80FF1234, 5'd5,  1'b1, 4'b0000, 32'h0,        32'hFFFF80FF};
    tbl[5]  = '{1'b1, 1'b0, 3'b000, 32'h100, 32'h0,        32'h0,    32'h80FF1234, 5'd6,  1'b1, 4'b0000, 32'h0,        32'h00000034};
    tbl[6]  = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0,        32'h0,    32'h80FF1234, 5'd7,  1'b1, 4'b0000, 32'h0,        32'h00000012};
    tbl[7]  = '{1'b1, 1'b0, 3'b000, 32'h102, 32'h0,        32'h0,    32'h80FF1234, 5'd8,  1'b1, 4'b0000, 32'h0,        32'hFFFFFFFF};
    tbl[8]  = '{1'b1, 1'b0, 3'b100, 32'h102, 32'h0,        32'h0,    32'h80FF1234, 5'd9,  1'b1, 4'b0000, 32'h0,        32'h000000FF};
    tbl[9]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        32'h0,    32'h80FF1234, 5'd10, 1'b1, 4'b0000, 32'h0,        32'h00001234};
    tbl[10] = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0,        32'h0,    32'h80FF1234, 5'd11, 1'b1, 4'b0000, 32'h0,        32'h80FF1234};
    tbl[11] = '{1'b1, 1'b0, 3'b011, 32'h103, 32'h0,        32'h0,    32'h80FF1234, 5'd12, 1'b1, 4'b0000, 32'h0,        32'h80FF1234};
    tbl[12] = '{1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h11,   32'h80FF1234, 5'd0,  1'b0, 4'b0010, 32'h0000AB00, 32'h00000011};
    tbl[13] = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h00001234, 32'h22,   32'h80FF1234, 5'd0,  1'b0, 4'b1100, 32'h12340000, 32'h00000022};
    tbl[14] = '{1'b0, 1'b1, 3'b001, 32'h200, 32'h00001234, 32'h33,   32'h80FF1234, 5'd0,  1'b0, 4'b0011, 32'h00001234, 32'h00000033};
    tbl[15] = '{1'b0, 1'b1, 3'b000, 32'h203, 32'h000000AB, 32'h44,   32'h80FF1234, 5'd0,  1'b0, 4'b1000, 32'hAB000000, 32'h00000044};
    tbl[16] = '{1'b0, 1'b1, 3'b010, 32'h203, 32'hCAFEF00D, 32'h66,   32'h80FF1234, 5'd0,  1'b0, 4'b1111, 32'hCAFEF00D, 32'h00000066};
    tbl[17] = '{1'b0, 1'b1, 3'b101, 32'h201, 32'hCAFEF00D, 32'h88,   32'h80FF1234, 5'd0,  1'b0, 4'b1111, 32'hCAFEF00D, 32'h00000088};
    tbl[18] = '{1'b0, 1'b0, 3'b000, 32'h0,   32'h0,        32'h55,   32'h0,        5'd3,  1'b1, 4'b0000, 32'h0,        32'h00000055};

    // Reset with a load presented: strobes must stay low.
    drive_idle();
    rst = 1'b1;
    drive_lw(32'h100, 5'd5);
    #1;
    chk("rst_read", {31'b0, dmem_read}, 32'h0);
    step();
    drive_idle();
    step();
    rst = 1'b0;
    #1;
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_rd", {27'b0, wb_rd}, 32'h0);
    chk("rst_wb_regwrite", {31'b0, wb_regwrite}, 32'h0);
    $display("reset: wb_valid=%0b wb_data=0x%08h", wb_valid, wb_data);

    // lw with response in the third cycle.
    step();
    drive_lw(32'h100, 5'd5);
    stall_cnt = 0;
    read_cnt  = 0;
    for (int c = 0; c < 3; c++) begin
      dmem_resp  = (c == 2);
      dmem_rdata = (c == 2) ? 32'hDEADBEEF : 32'h0;
      #1;
      if (mem_stall) stall_cnt++;
      if (dmem_read) read_cnt++;
      if (c == 0) chk("lw_wait_addr", dmem_address, 32'h100);
      step();
    end
    chk("lw_wait_wb_data", wb_data, 32'hDEADBEEF);
    chk("lw_wait_wb_rd", {27'b0, wb_rd}, 32'd5);
    chk("lw_wait_stall_cycles", stall_cnt, 32'd2);
    chk("lw_wait_read_cycles", read_cnt, 32'd3);
    $display("lw wait: wb_data=0x%08h stall_cycles=%0d", wb_data, stall_cnt);
    drive_idle();
    step();

    // lw answered immediately while stall_in is high for three cycles.
    drive_lw(32'h104, 5'd6);
    stall_in   = 1'b1;
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h12345678;
    read_cnt   = 0;
    #1;
    if (dmem_read) read_cnt++;
    chk("hold_resp_stall", {31'b0, mem_stall}, 32'h0);
    step();
    dmem_resp  = 1'b0;
    dmem_rdata = 32'hBAD0BAD0;
    for (int c = 0; c < 2; c++) begin
      #1;
      if (dmem_read) read_cnt++;
      chk("hold_mem_stall", {31'b0, mem_stall}, 32'h0);
      chk("hold_wb_frozen", wb_data, 32'h0);
      step();
    end
    stall_in = 1'b0;
    #1;
    if (dmem_read) read_cnt++;
    step();
    chk("hold_wb_data", wb_data, 32'h12345678);
    chk("hold_wb_rd", {27'b0, wb_rd}, 32'd6);
    chk("hold_read_cycles", read_cnt, 32'd1);
    $display("lw hold: wb_data=0x%08h read_cycles=%0d", wb_data, read_cnt);

    // Single-cycle accesses from the table.
    for (int i = 0; i < 19; i++) begin
      in_valid    = 1'b1;
      in_load     = tbl[i].ld;
      in_store    = tbl[i].st;
      in_funct3   = tbl[i].f3;
      in_addr     = tbl[i].addr;
      in_rs2      = tbl[i].rs2;
      in_alu      = tbl[i].alu;
      in_rd       = tbl[i].rd;
      in_regwrite = tbl[i].rw;
      stall_in    = 1'b0;
      dmem_resp   = tbl[i].ld | tbl[i].st;
      dmem_rdata  = tbl[i].rdata;
      #1;
      chk($sformatf("v%0d_read", i), {31'b0, dmem_read}, {31'b0, tbl[i].ld});
      chk($sformatf("v%0d_write", i), {31'b0, dmem_write}, {31'b0, tbl[i].st});
      chk($sformatf("v%0d_be", i), {28'b0, dmem_byte_enable}, {28'b0, tbl[i].be});
      chk($sformatf("v%0d_mem_stall", i), {31'b0, mem_stall}, 32'h0);
      if (tbl[i].ld | tbl[i].st)
        chk($sformatf("v%0d_addr", i), dmem_address, tbl[i].addr & 32'hFFFF_FFFC);
      if (tbl[i].st)
        chk($sformatf("v%0d_wdata", i), dmem_wdata, tbl[i].wdata);
      step();
      chk($sformatf("v%0d_wb_data", i), wb_data, tbl[i].wbd);
      chk($sformatf("v%0d_wb_valid", i), {31'b0, wb_valid}, 32'h1);
      chk($sformatf("v%0d_wb_rd", i), {27'b0, wb_rd}, {27'b0, tbl[i].rd});
      chk($sformatf("v%0d_wb_regwrite", i), {31'b0, wb_regwrite}, {31'b0, tbl[i].rw});
      $display("vec %0d: ld=%0b st=%0b f3=%0d addr=0x%03h be=%b wdata=0x%08h wb_data=0x%08h",
               i, tbl[i].ld, tbl[i].st, tbl[i].f3, tbl[i].addr, dmem_byte_enable, dmem_wdata, wb_data);
    end

    // Non-access instruction under external stall: WB registers hold.
    in_alu    = 32'h77;
    in_rd     = 5'd7;
    stall_in  = 1'b1;
    dmem_resp = 1'b0;
    #1;
    chk("alu_stall_read", {31'b0, dmem_read}, 32'h0);
    chk("alu_stall_write", {31'b0, dmem_write}, 32'h0);
    step();
    chk("alu_stall_wb_data", wb_data, 32'h55);
    chk("alu_stall_wb_rd", {27'b0, wb_rd}, 32'd3);
    stall_in = 1'b0;
    step();
    chk("alu_release_wb_data", wb_data, 32'h77);
    $display("alu stall: held then wb_data=0x%08h", wb_data);

    // Reset while waiting on the cache, then a stray response.
    drive_idle();
    drive_lw(32'h300, 5'd9);
    #1;
    chk("rstwait_read_idle", {31'b0, dmem_read}, 32'h1);
    step();
    chk("rstwait_read_wait", {31'b0, dmem_read}, 32'h1);
    chk("rstwait_stall_wait", {31'b0, mem_stall}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rstwait_read_in_rst", {31'b0, dmem_read}, 32'h0);
    step();
    rst = 1'b0;
    drive_idle();
    #1;
    chk("rstwait_read_after", {31'b0, dmem_read}, 32'h0);
    chk("rstwait_wb_valid", {31'b0, wb_valid}, 32'h0);
    chk("rstwait_wb_data", wb_data, 32'h0);
    chk("rstwait_mem_stall", {31'b0, mem_stall}, 32'h0);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h99999999;
    step();
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    chk("stray_wb_data", wb_data, 32'h0);
    chk("stray_wb_valid", {31'b0, wb_valid}, 32'h0);
    drive_lw(32'h304, 5'd10);
    #1;
    chk("post_rst_stall", {31'b0, mem_stall}, 32'h1);
    chk("post_rst_read", {31'b0, dmem_read}, 32'h1);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h01020304;
    step();
    chk("post_rst_wb_data", wb_data, 32'h01020304);
    $display("reset in wait: wb_data after new lw=0x%08h", wb_data);
    drive_idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
